stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Multi-cycle core controller that sequences the pipeline-less datapath through fetch, decode, exec, optional memory and writeback.
- Issues a one-cycle enable pulse to each stage and waits for that stage's one-cycle done pulse.
- Supports halt at an instruction boundary and resume from halt.
- A watchdog traps hung stages into an error state.
- Sits at core top level, driving the enable input and consuming the done output of every stage module.

Parameters:
- TIMEOUT, 1024, max wait cycles for a done pulse after an enable; 0 disables the watchdog.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  level; begins or resumes execution.
- halt_req  input  1  level; request stop at next instruction boundary.
- fetch_done  input  1  fetch stage done pulse.
- decode_done  input  1  decode stage done pulse.
- exec_done  input  1  exec stage done pulse.
- need_mem  input  1  from exec, sampled with exec_done; 1 means a memory stage is required.
- mem_done  input  1  memory stage done pulse.
- write_done  input  1  writeback stage done pulse.
- fetch_en  output  1  one-cycle enable pulse to fetch.
- decode_en  output  1  one-cycle enable pulse to decode.
- exec_en  output  1  one-cycle enable pulse to exec.
- mem_en  output  1  one-cycle enable pulse to memory.
- write_en  output  1  one-cycle enable pulse to writeback.
- busy  output  1  high in FETCH, DECODE, EXEC, MEM, WRITE.
- halted  output  1  high in HALT.
- err  output  1  high in ERROR.
- stage  output  3  current state encoding.
- instr_count  output  CNT_W  number of retired instructions.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-instruction) forces:
  - state IDLE, stage=0;
  - all enables 0, busy/halted/err 0;
  - instr_count 0, wait counter 0, halt_pending 0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WRITE=5, HALT=6, ERROR=7.
- Enable timing: on entry to a stage state S, S's enable is high for exactly the first cycle E in S. The stage's done is sampled from E+1 onward.
- Done handling:
  - A done seen in cycle D moves the FSM to the next state at D+1, where the next enable is high.
  - A done asserted in cycle E itself is ignored.
  - Done pulses from non-active stages are ignored in all states.
- Transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH -> DECODE -> EXEC.
  - EXEC: need_mem=1 with exec_done -> MEM, else -> WRITE.
  - MEM -> WRITE.
  - WRITE: on write_done, instr_count increments (wraps modulo 2^CNT_W). Next state is HALT if halt_pending or halt_req is 1 in that cycle, otherwise FETCH.
  - HALT: start=1 -> FETCH and halt_pending clears. start=1 arriving with halt_req=1 still stays in HALT.
  - ERROR: exits only through reset.
- halt_pending:
  - Set whenever halt_req=1 while busy.
  - Cleared on entry to HALT.
  - A halt never aborts an in-flight instruction.
- Watchdog:
  - The wait counter clears in E and increments each subsequent cycle in S without that stage's done.
  - With TIMEOUT>0, if no done has arrived by cycle E+TIMEOUT, the state is ERROR at E+TIMEOUT+1.
  - A done arriving exactly in E+TIMEOUT is accepted normally.
- Minimum timing: a stage with 1-cycle done latency occupies 2 cycles, so a non-memory instruction takes 8 cycles.
- start held high in FETCH..WRITE has no effect.

Test Plan:
- Reset, start=1 for 1 cycle, all stages answer done 1 cycle after enable, need_mem=0, halt_req=0 -> fetch_en at cycles 1 and 9; decode_en at 3, exec_en at 5, write_en at 7, mem_en never; instr_count=1 at cycle 9.
- Same as above with need_mem=1 at exec_done -> mem_en at cycle 7, write_en at 9, next fetch_en at 11; 5 instructions give instr_count=5.
- Decode done 2 cycles after enable -> decode_en at 3, decode_done at 5, exec_en at 6.
  - Also inject a stray mem_done and a decode_done coincident with decode_en: both ignored, stage stays 2.
- halt_req pulsed 1 cycle during EXEC -> instruction completes, instr_count increments, stage=6, halted=1, no further fetch_en.
  - Then start=1 -> fetch_en next cycle, halted=0.
- TIMEOUT=4, withhold exec_done -> stage=7 and err=1 at E+5, no enables afterwards.
  - Repeat with exec_done at E+4: proceeds to WRITE normally.
- Assert rstn=0 asynchronously mid-MEM (between clock edges) -> all outputs 0 immediately, instr_count=0.
  - After release, the FSM stays IDLE until start.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// stage_sequencer_if
//   Bundles the sequencer <-> stage handshake: one enable pulse out to each
//   stage and one done pulse back from each stage. Exec also returns need_mem,
//   which is only meaningful in the cycle exec_done is high.
//
//   modport master : sequencer side (drives enables, observes dones)
//   modport slave  : stage side    (observes enables, drives dones)
// ---------------------------------------------------------------------------
interface stage_sequencer_if;
  logic fetch_en;
  logic decode_en;
  logic exec_en;
  logic mem_en;
  logic write_en;

  logic fetch_done;
  logic decode_done;
  logic exec_done;
  logic need_mem;
  logic mem_done;
  logic write_done;

  modport master (
    output fetch_en, decode_en, exec_en, mem_en, write_en,
    input  fetch_done, decode_done, exec_done, need_mem, mem_done, write_done
  );

  modport slave (
    input  fetch_en, decode_en, exec_en, mem_en, write_en,
    output fetch_done, decode_done, exec_done, need_mem, mem_done, write_done
  );
endinterface

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
//   Multi-cycle core controller. Walks the datapath through
//   FETCH -> DECODE -> EXEC -> [MEM] -> WRITE, issuing a one-cycle enable on
//   entry to each stage and advancing on that stage's done pulse. Supports
//   halting at an instruction boundary, resuming from halt, and a watchdog
//   that traps a stage that never answers into ERROR.
//
// Ports
//   clk          core clock, rising edge
//   rstn         asynchronous active-low reset
//   start        level; begins execution from IDLE or resumes from HALT
//   halt_req     level; stop at the next instruction boundary
//   stg          stage handshake bundle (master side)
//   busy         high in FETCH..WRITE
//   halted       high in HALT
//   err          high in ERROR
//   stage        current state encoding (IDLE=0 .. ERROR=7)
//   instr_count  retired-instruction counter, wraps modulo 2^CNT_W
//
// Parameters
//   TIMEOUT      cycles allowed for a done after an enable; 0 disables
//   CNT_W        width of instr_count
// ---------------------------------------------------------------------------
module stage_sequencer #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 halt_req,
  stage_sequencer_if.master    stg,
  output logic                 busy,
  output logic                 halted,
  output logic                 err,
  output logic [2:0]           stage,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WRITE  = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  localparam int NUM_STAGES = 5;

  // The wait counter only has to reach TIMEOUT; it saturates afterwards so a
  // disabled watchdog never wraps back into a small value.
  localparam int                WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;

  state_t                  state_q, state_d;
  logic [NUM_STAGES-1:0]   en_q, en_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    halted_q, halted_d;
  logic                    err_q, err_d;

  logic [NUM_STAGES-1:0]   done_vec;
  logic [NUM_STAGES-1:0]   sel_done;
  logic                    in_stage;
  logic                    active_done;
  logic                    wd_expired;
  logic                    entering;

  // Bit i of the stage vectors belongs to the state encoded as i+1.
  assign done_vec = {stg.write_done, stg.mem_done, stg.exec_done,
                     stg.decode_done, stg.fetch_done};

  // Only the done of the stage currently being waited on is visible.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_done_sel
      assign sel_done[gi] = done_vec[gi] && (state_q == state_t'(3'(gi + 1)));
    end
  endgenerate

  assign in_stage = (state_q >= ST_FETCH) && (state_q <= ST_WRITE);

  // A done coincident with the stage's own enable cycle is ignored; the
  // enable is registered, so en_q being high marks exactly that cycle.
  assign active_done = (|sel_done) && !(|en_q);

  // wait_q equals k in cycle E+k, so the trap fires when E+TIMEOUT passes
  // without a done; a done in that same cycle still wins.
  assign wd_expired = (TIMEOUT > 0) && in_stage && (wait_q >= WAIT_LIMIT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    halt_pend_d = halt_pend_q;
    wait_d      = wait_q;
    en_d        = '0;
    entering    = 1'b0;
    busy_d      = 1'b0;
    halted_d    = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (active_done)     state_d = ST_DECODE;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_DECODE: begin
        if (active_done)     state_d = ST_EXEC;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_EXEC: begin
        // need_mem is only qualified by the accepted exec_done.
        if (active_done)     state_d = stg.need_mem ? ST_MEM : ST_WRITE;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_MEM: begin
        if (active_done)     state_d = ST_WRITE;
        else if (wd_expired) state_d = ST_ERROR;
      end
      ST_WRITE: begin
        if (active_done) begin
          cnt_d   = cnt_q + CNT_W'(1);
          // A request arriving in the retire cycle itself still halts here.
          state_d = (halt_pend_q || halt_req) ? ST_HALT : ST_FETCH;
        end else if (wd_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_HALT: begin
        // Resume only once the halt request has been dropped.
        if (start && !halt_req) state_d = ST_FETCH;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase

    // A halt request is remembered while an instruction is in flight and
    // consumed when HALT is entered.
    if (in_stage && halt_req) halt_pend_d = 1'b1;
    if ((state_d == ST_HALT) && (state_q != ST_HALT)) halt_pend_d = 1'b0;

    entering = (state_d != state_q);

    if (entering) begin
      wait_d = '0;
    end else if (in_stage && (wait_q != WAIT_MAX)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    // No stage state ever transitions to itself, so every entry is a fresh
    // enable pulse lasting one cycle.
    for (int i = 0; i < NUM_STAGES; i++) begin
      en_d[i] = entering && (state_d == state_t'(3'(i + 1)));
    end

    busy_d   = (state_d >= ST_FETCH) && (state_d <= ST_WRITE);
    halted_d = (state_d == ST_HALT);
    err_d    = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      en_q        <= '0;
      wait_q      <= '0;
      halt_pend_q <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      wait_q      <= wait_d;
      halt_pend_q <= halt_pend_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end

  assign stg.fetch_en  = en_q[0];
  assign stg.decode_en = en_q[1];
  assign stg.exec_en   = en_q[2];
  assign stg.mem_en    = en_q[3];
  assign stg.write_en  = en_q[4];

  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign stage       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stage_sequencer
//   Randomised stage latencies, need_mem, stray dones, halt requests and
//   start noise. Expected enable events (stage, cycle, instr_count) are
//   computed from the latencies with plain arithmetic and queued; a monitor
//   on the falling edge pops and compares each observed enable pulse.
// ---------------------------------------------------------------------------
module tb_stage_sequencer;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic             halt_req = 1'b0;
  logic             busy;
  logic             halted;
  logic             err;
  logic [2:0]       stage;
  logic [CNT_W-1:0] instr_count;

  stage_sequencer_if bif ();

  stage_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .halt_req    (halt_req),
    .stg         (bif),
    .busy        (busy),
    .halted      (halted),
    .err         (err),
    .stage       (stage),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int stg;
    int cyc;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Stimulus knobs for the instruction currently being issued.
  int  lat[5];
  bit  nm;
  int  halt_stage;
  bit  strays;
  bit  coinc;
  bit  snoise;
  int  cnt_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic logic [4:0] en_vec();
    return {bif.write_en, bif.mem_en, bif.exec_en, bif.decode_en, bif.fetch_en};
  endfunction

  // Monitor: every enable pulse must match the head of the expected queue.
  always @(negedge clk) begin : mon
    ev_t        e;
    logic [4:0] ev;
    if (rstn === 1'b1) begin
      ev = en_vec();
      if (ev != 5'd0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_en", 32'(ev), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("en_stage", 32'(ev), 32'(1) << (e.stg - 1));
          chk("en_cycle", cyc, e.cyc);
          chk("count_at_en", 32'(instr_count), e.cnt);
          chk("stage_at_en", 32'(stage), e.stg);
          chk("busy_at_en", 32'(busy), 32'd1);
          $display("en stage=%0d cycle=%0d count=%0d (exp stage=%0d cycle=%0d count=%0d)",
                   stage, cyc, instr_count, e.stg, e.cyc, e.cnt);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_drive();
    bif.fetch_done  = 1'b0;
    bif.decode_done = 1'b0;
    bif.exec_done   = 1'b0;
    bif.mem_done    = 1'b0;
    bif.write_done  = 1'b0;
    bif.need_mem    = 1'b0;
    halt_req        = 1'b0;
    start           = 1'b0;
  endtask

  task automatic drive_dones(input logic [4:0] d);
    bif.fetch_done  = d[0];
    bif.decode_done = d[1];
    bif.exec_done   = d[2];
    bif.mem_done    = d[3];
    bif.write_done  = d[4];
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_enables"}, 32'(en_vec()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_stage"}, 32'(stage), 32'd0);
    chk({tag, "_count"}, 32'(instr_count), 32'd0);
  endtask

  // Reference model: enable of stage s at t, its done at t+lat, next enable
  // at t+lat+1. Returns the cycle of the following fetch enable.
  function automatic int push_instr(input int tf, input bit stop_at_exec);
    int  t;
    ev_t e;
    t = tf;
    for (int s = 0; s < 5; s++) begin
      if (s == 3 && !nm) continue;
      e.stg = s + 1;
      e.cyc = t;
      e.cnt = cnt_model;
      exp_q.push_back(e);
      if (stop_at_exec && s == 2) return 0;
      t += lat[s] + 1;
    end
    return t;
  endfunction

  task automatic wait_en(input int s);
    logic [4:0] v;
    for (int i = 0; i < 32; i++) begin
      v = en_vec();
      if (v[s]) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL wait_en: stage %0d enable got 0 for 32 cycles, expected 1", s + 1);
    finish_sim();
  endtask

  // Called in the enable cycle of stage s; drives the done lat[s] cycles
  // later plus whatever noise the knobs ask for.
  task automatic run_stage(input int s);
    logic [4:0] d;
    for (int k = 0; k <= lat[s]; k++) begin
      d = 5'd0;
      if (strays) begin
        d = 5'($urandom) & 5'($urandom);
        d[s] = 1'b0;
      end
      if (k == lat[s] || (k == 0 && coinc)) d[s] = 1'b1;
      drive_dones(d);
      bif.need_mem = (s == 2 && k == lat[s]) ? nm : 1'($urandom);
      halt_req     = (s == halt_stage) && (k == lat[s]);
      start        = snoise ? 1'($urandom) : 1'b0;
      step();
    end
    clear_drive();
  endtask

  task automatic run_instr();
    for (int s = 0; s < 5; s++) begin
      if (s == 3 && !nm) continue;
      wait_en(s);
      run_stage(s);
    end
  endtask

  task automatic issue_start(output int tf);
    start = 1'b1;
    tf    = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic rand_instr(input bit allow_halt);
    for (int s = 0; s < 5; s++) lat[s] = $urandom_range(1, TIMEOUT);
    nm         = 1'($urandom);
    halt_stage = (allow_halt && $urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1;
    if (halt_stage == 3 && !nm) halt_stage = 4;
    strays     = 1'($urandom);
    coinc      = 1'($urandom);
    snoise     = (halt_stage < 0) ? 1'($urandom) : 1'b0;
  endtask

  initial begin
    #2000000;
    checks++;
    errors++;
    $display("FAIL global_timeout: simulation still running at cycle %0d, expected done", cyc);
    finish_sim();
  end

  initial begin
    int tf;
    int tf_next;

    clear_drive();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rstn = 1'b1;
    step();
    step();
    chk("idle_without_start", 32'(stage), 32'd0);
    cnt_model = 0;

    // Main randomised run; the count wraps past 2^CNT_W.
    issue_start(tf);
    for (int n = 0; n < 40; n++) begin
      rand_instr(1'b1);
      if (n < 2) begin
        for (int s = 0; s < 5; s++) lat[s] = 1;
        nm = (n == 1); halt_stage = -1; strays = 0; coinc = 0; snoise = 0;
      end
      tf_next = push_instr(tf, 1'b0);
      run_instr();
      cnt_model = (cnt_model + 1) % (1 << CNT_W);
      if (halt_stage >= 0) begin
        chk("halt_stage", 32'(stage), 32'd6);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_count", 32'(instr_count), cnt_model);
        repeat ($urandom_range(0, 2)) step();
        if ($urandom_range(0, 1) == 1) begin
          start = 1'b1;
          halt_req = 1'b1;
          step();
          clear_drive();
          chk("halt_hold_stage", 32'(stage), 32'd6);
        end
        issue_start(tf);
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_busy", 32'(busy), 32'd1);
      end else begin
        tf = tf_next;
      end
    end

    // Done arriving exactly at E+TIMEOUT is accepted.
    rand_instr(1'b0);
    lat[2] = TIMEOUT;
    nm = 1'b0;
    tf_next = push_instr(tf, 1'b0);
    run_instr();
    cnt_model = (cnt_model + 1) % (1 << CNT_W);
    tf = tf_next;

    // Withheld exec_done traps into ERROR at E+TIMEOUT+1.
    rand_instr(1'b0);
    snoise = 1'b0;
    void'(push_instr(tf, 1'b1));
    wait_en(0);
    run_stage(0);
    wait_en(1);
    run_stage(1);
    wait_en(2);
    repeat (TIMEOUT) step();
    chk("wd_stage_at_limit", 32'(stage), 32'd3);
    chk("wd_err_at_limit", 32'(err), 32'd0);
    step();
    chk("wd_stage_error", 32'(stage), 32'd7);
    chk("wd_err", 32'(err), 32'd1);
    chk("wd_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive_dones(5'($urandom));
      start = 1'($urandom);
      step();
    end
    clear_drive();
    chk("error_sticky", 32'(stage), 32'd7);

    // Reset out of ERROR with a non-zero count.
    rstn = 1'b0;
    #1;
    check_reset_state("reset_from_error");
    exp_q.delete();
    step();
    rstn = 1'b1;
    step();
    cnt_model = 0;
    chk("idle_after_error_reset", 32'(stage), 32'd0);

    issue_start(tf);
    for (int n = 0; n < 2; n++) begin
      rand_instr(1'b0);
      tf = push_instr(tf, 1'b0);
      run_instr();
      cnt_model = (cnt_model + 1) % (1 << CNT_W);
    end

    // Asynchronous reset between edges while in MEM.
    rand_instr(1'b0);
    nm = 1'b1;
    snoise = 1'b0;
    void'(push_instr(tf, 1'b1));
    for (int s = 0; s < 3; s++) begin
      wait_en(s);
      run_stage(s);
    end
    wait_en(3);
    chk("pre_reset_stage_mem", 32'(stage), 32'd4);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_state("async_reset_mid_mem");
    exp_q.delete();
    cnt_model = 0;
    step();
    rstn = 1'b1;
    repeat (5) step();
    chk("idle_after_async_reset", 32'(stage), 32'd0);
    chk("idle_busy_after_async_reset", 32'(busy), 32'd0);

    // One more instruction, ending in HALT so nothing more is fetched.
    issue_start(tf);
    rand_instr(1'b0);
    halt_stage = 4;
    snoise = 1'b0;
    void'(push_instr(tf, 1'b0));
    run_instr();
    cnt_model = (cnt_model + 1) % (1 << CNT_W);
    chk("final_halted", 32'(halted), 32'd1);
    chk("final_count", 32'(instr_count), cnt_model);
    repeat (4) step();
    chk("queue_empty", exp_q.size(), 32'd0);
    finish_sim();
  end

endmodule
